// File: rtl/imem_if.sv
// Fetch read channel between the fetch stage (master) and the instruction memory (slave).
interface imem_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one word read in flight, fixed wait-state latency,
// with a loader write port that patches words in any state.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  imem_if.slave       bus,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WA_W  = 30;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             accept_c;
  logic [31:0]      rd_addr_c;
  logic             rd_err_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic             ld_ok_c;
  logic [IDX_W-1:0] ld_idx_c;

  logic [31:0] mem [DEPTH_WORDS];

  // Next-state, wait counter and captured request address
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    accept_c = bus.req_valid && bus.req_ready;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        if (accept_c) begin
          addr_d = bus.req_addr;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
    endcase
  end

  // With zero wait states the read is registered on the accept edge itself
  always_comb begin
    rd_addr_c = accept_c ? bus.req_addr : addr_q;
    rd_err_c  = (rd_addr_c[1:0] != 2'b00) || (rd_addr_c[31:2] >= WA_W'(DEPTH_WORDS));
    rd_idx_c  = rd_addr_c[IDX_W+1:2];
    ld_ok_c   = ld_we && (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < WA_W'(DEPTH_WORDS));
    ld_idx_c  = ld_addr[IDX_W+1:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      bus.req_ready <= (state_d != S_WAIT);
      bus.rsp_valid <= (state_d == S_RESP);
      if (state_d == S_RESP) begin
        bus.rsp_err  <= rd_err_c;
        bus.rsp_data <= rd_err_c ? 32'h0 : mem[rd_idx_c];
      end
    end
  end

  // Array is not reset; a same-edge write is invisible to the read registered on that edge
  always_ff @(posedge clk) begin
    if (ld_ok_c) mem[ld_idx_c] <= ld_data;
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (0, 1 and 3 wait states) driven by directed
// and random traffic, checked against a cycle-level transaction model.
module tb_imem_responder;
  localparam int unsigned DEPTH = 64;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic reset;

  logic        rv  [NDUT];
  logic [31:0] ra  [NDUT];
  logic        lwe [NDUT];
  logic [31:0] la  [NDUT];
  logic [31:0] ld  [NDUT];

  imem_if b0 ();
  imem_if b1 ();
  imem_if b3 ();

  assign b0.req_valid = rv[0];
  assign b0.req_addr  = ra[0];
  assign b1.req_valid = rv[1];
  assign b1.req_addr  = ra[1];
  assign b3.req_valid = rv[2];
  assign b3.req_addr  = ra[2];

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(reset), .bus(b0), .ld_we(lwe[0]), .ld_addr(la[0]), .ld_data(ld[0]));
  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_w1 (
    .clk(clk), .reset(reset), .bus(b1), .ld_we(lwe[1]), .ld_addr(la[1]), .ld_data(ld[1]));
  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(reset), .bus(b3), .ld_we(lwe[2]), .ld_addr(la[2]), .ld_data(ld[2]));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Transaction model: memory image, one outstanding request, last response
  logic [31:0] mm      [NDUT][DEPTH];
  int          next_ok [NDUT];
  bit          pend_v  [NDUT];
  int          pend_due[NDUT];
  logic [31:0] pend_a  [NDUT];
  logic [31:0] held_d  [NDUT];
  logic        held_e  [NDUT];

  function automatic int ws(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel <= 6)      return 32'($urandom_range(0, DEPTH - 1) * 4);
    else if (sel == 7) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    else if (sel == 8) return 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
    else               return $urandom;
  endfunction

  task automatic sample(input int k, output logic r, output logic v,
                        output logic [31:0] d, output logic e);
    case (k)
      0:       begin r = b0.req_ready; v = b0.rsp_valid; d = b0.rsp_data; e = b0.rsp_err; end
      1:       begin r = b1.req_ready; v = b1.rsp_valid; d = b1.rsp_data; e = b1.rsp_err; end
      default: begin r = b3.req_ready; v = b3.rsp_valid; d = b3.rsp_data; e = b3.rsp_err; end
    endcase
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h cyc=%0d", tag, k, obs, exp, cyc);
    end
  endtask

  // One clock: predict accepts/responses/loads for this edge, then check outputs after it
  task automatic tick();
    bit          due [NDUT];
    logic        r, v, e;
    logic [31:0] d;
    for (int k = 0; k < NDUT; k++) begin
      sample(k, r, v, d, e);
      chk("req_ready", k, 32'(r), 32'(cyc >= next_ok[k]));
      if (rv[k] && cyc >= next_ok[k]) begin
        pend_v[k]   = 1'b1;
        pend_due[k] = cyc + ws(k);
        pend_a[k]   = ra[k];
        next_ok[k]  = cyc + ws(k) + 1;
      end
      due[k] = pend_v[k] && (pend_due[k] == cyc);
      if (due[k]) begin
        pend_v[k] = 1'b0;
        held_e[k] = addr_bad(pend_a[k]);
        held_d[k] = held_e[k] ? 32'h0 : mm[k][widx(pend_a[k])];
      end
      if (lwe[k] && !addr_bad(la[k])) mm[k][widx(la[k])] = ld[k];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      sample(k, r, v, d, e);
      chk("rsp_valid", k, 32'(v), 32'(due[k]));
      chk("rsp_data", k, d, held_d[k]);
      chk("rsp_err", k, 32'(e), 32'(held_e[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      pend_v[k]  = 1'b0;
      next_ok[k] = cyc;
      held_d[k]  = 32'h0;
      held_e[k]  = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < NDUT; k++) begin
      rv[k] = 1'b0; ra[k] = 32'h0; lwe[k] = 1'b0; la[k] = 32'h0; ld[k] = 32'h0;
    end
  endtask

  task automatic load_all(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < NDUT; k++) begin
      lwe[k] = 1'b1; la[k] = a; ld[k] = w;
    end
    tick();
    for (int k = 0; k < NDUT; k++) lwe[k] = 1'b0;
  endtask

  initial begin
    logic        r, v, e;
    logic [31:0] d;
    int          zeros, rsps;

    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < NDUT; k++) begin
      sample(k, r, v, d, e);
      chk("reset_ready", k, 32'(r), 32'(1));
      chk("reset_valid", k, 32'(v), 32'(0));
      chk("reset_data", k, d, 32'h0);
      chk("reset_err", k, 32'(e), 32'(0));
    end

    // Preload every word, then the words used by the directed cases
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int k = 0; k < NDUT; k++) begin
        lwe[k] = 1'b1; la[k] = 32'(i * 4); ld[k] = $urandom;
      end
      tick();
    end
    idle_inputs();
    load_all(32'h10, 32'h1122_3344);
    load_all(32'h00, 32'hA5A5_0000);
    load_all(32'h04, 32'h0000_5A5A);
    load_all(32'h08, 32'hCAFE_BABE);
    load_all(32'h20, 32'h0BAD_F00D);

    // One wait state: accept at edge N, response visible only after edge N+1
    rv[1] = 1'b1; ra[1] = 32'h10;
    tick();
    rv[1] = 1'b0;
    sample(1, r, v, d, e);
    chk("w1_early_valid", 1, 32'(v), 32'(0));
    tick();
    sample(1, r, v, d, e);
    chk("w1_valid", 1, 32'(v), 32'(1));
    chk("w1_data", 1, d, 32'h1122_3344);
    chk("w1_err", 1, 32'(e), 32'(0));
    tick();
    sample(1, r, v, d, e);
    chk("w1_pulse_end", 1, 32'(v), 32'(0));
    chk("w1_data_held", 1, d, 32'h1122_3344);

    // Zero wait states, back-to-back
    rv[0] = 1'b1; ra[0] = 32'h0;
    tick();
    sample(0, r, v, d, e);
    chk("b2b_0", 0, d, 32'hA5A5_0000);
    chk("b2b_0_valid", 0, 32'(v), 32'(1));
    ra[0] = 32'h4;
    tick();
    sample(0, r, v, d, e);
    chk("b2b_1", 0, d, 32'h0000_5A5A);
    chk("b2b_1_valid", 0, 32'(v), 32'(1));
    ra[0] = 32'h8;
    tick();
    sample(0, r, v, d, e);
    chk("b2b_2", 0, d, 32'hCAFE_BABE);
    chk("b2b_2_valid", 0, 32'(v), 32'(1));

    // Misaligned and first out-of-range address
    ra[0] = 32'h2;
    tick();
    sample(0, r, v, d, e);
    chk("misalign_err", 0, 32'(e), 32'(1));
    chk("misalign_data", 0, d, 32'h0);
    ra[0] = 32'(4 * DEPTH);
    tick();
    sample(0, r, v, d, e);
    chk("oor_err", 0, 32'(e), 32'(1));
    chk("oor_data", 0, d, 32'h0);
    rv[0] = 1'b0;
    tick();

    // Loader write on the edge that registers the read returns the old word
    rv[1] = 1'b1; ra[1] = 32'h20;
    tick();
    rv[1] = 1'b0;
    lwe[1] = 1'b1; la[1] = 32'h20; ld[1] = 32'hDEAD_BEEF;
    tick();
    lwe[1] = 1'b0;
    sample(1, r, v, d, e);
    chk("hazard_old", 1, d, 32'h0BAD_F00D);
    tick();
    rv[1] = 1'b1; ra[1] = 32'h20;
    tick();
    rv[1] = 1'b0;
    tick();
    sample(1, r, v, d, e);
    chk("hazard_new", 1, d, 32'hDEAD_BEEF);

    // Three wait states with req_valid held continuously
    rv[2] = 1'b1; ra[2] = 32'h10;
    zeros = 0;
    rsps  = 0;
    repeat (8) begin
      tick();
      sample(2, r, v, d, e);
      if (!r) zeros++;
      if (v)  rsps++;
    end
    rv[2] = 1'b0;
    chk("stall_ready_low", 2, 32'(zeros), 32'(6));
    chk("stall_rsp_count", 2, 32'(rsps), 32'(2));
    tick();

    // Reset in the middle of a wait, after an error response was left on the bus
    rv[2] = 1'b1; ra[2] = 32'h3;
    tick();
    rv[2] = 1'b0;
    repeat (3) tick();
    rv[2] = 1'b1; ra[2] = 32'h10;
    tick();
    rv[2] = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < NDUT; k++) begin
      sample(k, r, v, d, e);
      chk("midrst_ready", k, 32'(r), 32'(1));
      chk("midrst_valid", k, 32'(v), 32'(0));
      chk("midrst_err", k, 32'(e), 32'(0));
      chk("midrst_data", k, d, 32'h0);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
    model_reset();
    repeat (6) tick();

    // Random traffic on all three instances
    repeat (800) begin
      for (int k = 0; k < NDUT; k++) begin
        rv[k]  = ($urandom_range(0, 2) != 0);
        ra[k]  = rand_addr();
        lwe[k] = ($urandom_range(0, 3) == 0);
        la[k]  = rand_addr();
        ld[k]  = $urandom;
      end
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
